crc_engine_fifo: RTL
====================

Name: crc_engine_fifo

Overview:
Parametrised bus-mapped CRC engine, next generation of the single-word bit-serial CRC peripheral.
- Adds configurable CRC width and bits-per-cycle throughput.
- Adds a data FIFO, so the CPU can write words back-to-back without polling.
- Adds a final-XOR register, a completion interrupt and overflow detection.
- Sits behind the TinyQV peripheral wrapper on the same cs/rs/wrl/d/q register bus.

Parameters:
- W, 32: CRC width in bits. Legal values are 8..32.
- STEP, 1: data bits consumed per clock. Legal values are 1, 2, 4, 8.
- DEPTH, 4: FIFO depth in entries. Must be a power of 2, minimum 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- cs  in  1  chip select for a bus access.
- rs  in  3  register select.
- wrl  in  4  write byte lanes: 0001 = 8-bit, 0011 = 16-bit, 1111 = 32-bit, 0000 = read.
- d  in  32  write data.
- q  out  32  read data, combinational from rs.
- irq  out  1  level interrupt, equal to irq_pend & ien.

Behaviour:
Write register map (a write is cs & wrl!=0):
- rs=0, CRC: crc[W-1:0] <= d[31:32-W] (MSB-justified).
- rs=1, POLY: poly <= d[31:32-W].
- rs=2, DATA: push one entry {payload = byte-swapped d, so d[7:0] lands in payload[31:24]; len = 8/16/32 from wrl}.
- rs=3, REFL: push one entry {payload = bit-reverse of d[31:0]; len from wrl}.
- rs=4, CTRL: d[0] = ien. d[1] = 1 clears irq_pend. d[2] = 1 clears ovf. Bits 1 and 2 are self-clearing.
- rs=5, XOROUT: xorout[W-1:0] <= d[W-1:0] (LSB-justified).
- rs=6,7: writes ignored.

Read register map:
- rs=0: {crc, (32-W) zeros}.
- rs=1, STAT: {fill[5:0] at bits 9:4, ovf at bit 3, irq_pend at bit 2, full at bit 1, idle at bit 0}. Remaining bits are 0.
- rs=2: bit-reverse of crc, placed in q[W-1:0], XOR xorout. q[31:W] = 0.
- rs=3: crc XOR xorout placed in q[W-1:0], no reflection.
- rs=4: {31'b0, ien}.
- rs=5: xorout, zero-extended.
- rs=6,7: 0.

FIFO:
- DEPTH entries, each 32-bit payload plus 6-bit len.
- A push while full is dropped and sets sticky ovf. Fullness is sampled before any same-cycle pop.
- fill counts FIFO entries only, not the word in the shifter.

Engine FSM (reset state IDLE):
- IDLE: if FIFO non-empty, pop into sh and set cnt=len, then go to SHIFT. This costs 1 cycle.
- SHIFT: each cycle, apply STEP serial steps, MSB first. Each step: fb = crc[W-1]^sh[31]; crc = {crc[W-2:0],0} ^ (fb ? poly : 0); sh <<= 1. Then cnt -= STEP.
- When cnt reaches 0:
  - If FIFO non-empty, pop the next entry in that same cycle and stay in SHIFT (no bubble).
  - Otherwise go to IDLE and set irq_pend.
- Latency from push into an empty, idle engine to idle=1: 1 + len/STEP cycles.
- idle = (state==IDLE) & FIFO empty.

Boundary conditions:
- CRC write during SHIFT: the write wins that cycle. That cycle's step is discarded and shifting continues from the written value on the next cycle.
- POLY or XOROUT write during SHIFT takes effect on the next step. Software is responsible for this.
- A CTRL clear of irq_pend in the same cycle as a completion: the set wins.
- Reset mid-operation returns all of the following to 0 / IDLE: FIFO pointers, fill, cnt, state, irq_pend, ovf, ien, xorout. crc, poly and sh also reset to 0.
- Reset values: q follows rs with reset register contents; irq=0.

Test Plan:
- CRC-32/ISO-HDLC check, W=32, STEP=1:
  - Write POLY=0x04C11DB7, CRC=0xFFFFFFFF, XOROUT=0xFFFFFFFF.
  - 8-bit REFL writes of ASCII "123456789".
  - Poll idle, read rs=2 -> 0xCBF43926.
- CRC-16/CCITT-FALSE, W=16, STEP=4:
  - POLY=0x10210000, CRC=0xFFFF0000, XOROUT=0.
  - DATA byte writes "123456789".
  - Read rs=3 -> 0x000029B1.
  - Idle asserted exactly 1+2 cycles after a single push into an idle engine.
- CRC-8, W=8, STEP=8:
  - POLY=0x07000000, CRC=0.
  - One 32-bit DATA write of 0x34333231 ("1234", LSB byte first), then 16-bit write 0x3635, then 8-bit writes "7","8","9".
  - Read rs=3 -> 0xF4.
  - Confirm the 32-bit push takes 4 shift cycles.
- Back-to-back and overflow, DEPTH=4, STEP=1:
  - Push 6 words consecutively.
  - fill reads 4 and full=1; the 6th push sets ovf=1.
  - The CRC result equals the golden value computed over the 5 accepted words. The SHIFT state has no idle gap between words.
  - CTRL d[2] clears ovf.
- Interrupt:
  - With ien=1, push one word. irq rises on the cycle idle becomes 1.
  - CTRL d[1]=1 drops irq. Pushing a new word and completing raises it again.
  - With ien=0, irq stays 0 while irq_pend=1.
- Reset mid-operation:
  - Push 3 words, assert reset during SHIFT of word 1.
  - Afterwards STAT = 0x00000001 and irq=0.
  - A subsequent full CRC-32 run still produces 0xCBF43926.

Source files
------------

// File: rtl/crc_engine_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : crc_engine_fifo_if
//  Description : Register-bus bundle between a CPU-side master and the CRC
//                engine. The master drives the access (cs, rs, wrl, d). The
//                engine returns read data (q) and its interrupt line (irq).
//  Signals     : cs   - access strobe
//                rs   - register select (3 bits)
//                wrl  - write byte lanes; 0000 means a read
//                d    - write data (32 bits)
//                q    - read data (32 bits), combinational from rs
//                irq  - level interrupt
//  Revision    : 1.0 - initial release
// ============================================================================
interface crc_engine_fifo_if;
    logic        cs;
    logic [2:0]  rs;
    logic [3:0]  wrl;
    logic [31:0] d;
    logic [31:0] q;
    logic        irq;

    modport master (output cs, rs, wrl, d, input q, irq);
    modport slave  (input cs, rs, wrl, d, output q, irq);
endinterface
`default_nettype wire

// File: rtl/crc_engine_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : crc_engine_fifo
//  Description : Bus-mapped CRC engine. Data words written by the CPU are
//                queued in a small FIFO. A shifter then feeds them MSB-first
//                into a W-bit CRC register, consuming STEP bits per clock.
//                Includes a final-XOR register, a completion interrupt and a
//                sticky overflow flag.
//  Ports       : clk   - system clock
//                reset - asynchronous reset, active high
//                bus   - register bus (cs/rs/wrl/d in, q/irq out)
//  Parameters  : W     - CRC width, 8..32
//                STEP  - bits consumed per clock: 1, 2, 4 or 8
//                DEPTH - FIFO entries, a power of 2 and at least 2
//  Revision    : 1.0 - initial release
// ============================================================================
module crc_engine_fifo #(
    parameter int W     = 32,
    parameter int STEP  = 1,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    crc_engine_fifo_if.slave  bus
);
    localparam int         AW      = $clog2(DEPTH);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;
    localparam logic [5:0] C_STEP  = 6'(STEP);

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------
    logic [0:0]    state_q, state_d;
    logic [W-1:0]  crc_q, crc_d;
    logic [W-1:0]  poly_q, poly_d;
    logic [W-1:0]  xorout_q, xorout_d;
    logic [31:0]   sh_q, sh_d;
    logic [5:0]    cnt_q, cnt_d;
    logic          ien_q, ien_d;
    logic          pend_q, pend_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   fill_q, fill_d;

    logic [31:0]   fifo_pay_q [DEPTH];
    logic [5:0]    fifo_len_q [DEPTH];

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic          wr_en;
    logic [5:0]    wr_len;
    logic          push_req;
    logic          push_ok;
    logic          full;
    logic          empty;
    logic          idle;
    logic [31:0]   push_payload;

    assign wr_en    = bus.cs && (bus.wrl != 4'b0000);
    assign push_req = wr_en && ((bus.rs == 3'd2) || (bus.rs == 3'd3));
    assign full     = (fill_q == (AW+1)'(DEPTH));
    assign empty    = (fill_q == '0);
    // Fullness is taken before any same-cycle pop, so a push into a full
    // FIFO is dropped even when the engine frees a slot on that edge.
    assign push_ok  = push_req && !full;

    always_comb begin
        case (bus.wrl)
            4'b0001: wr_len = 6'd8;
            4'b0011: wr_len = 6'd16;
            default: wr_len = 6'd32;
        endcase
    end

    // DATA entries are byte-swapped so the lowest byte is shifted first;
    // REFL entries are fully bit-reversed for reflected-input CRCs.
    always_comb begin
        push_payload = {bus.d[7:0], bus.d[15:8], bus.d[23:16], bus.d[31:24]};
        if (bus.rs == 3'd3) begin
            for (int i = 0; i < 32; i++) begin
                push_payload[i] = bus.d[31-i];
            end
        end
    end

    // ------------------------------------------------------------------
    // STEP serial CRC steps unrolled into one clock
    // ------------------------------------------------------------------
    logic [W-1:0] step_crc;
    logic [31:0]  step_sh;
    logic         fb;

    always_comb begin
        step_crc = crc_q;
        step_sh  = sh_q;
        fb       = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            fb       = step_crc[W-1] ^ step_sh[31];
            step_crc = {step_crc[W-2:0], 1'b0} ^ (fb ? poly_q : '0);
            step_sh  = {step_sh[30:0], 1'b0};
        end
    end

    // ------------------------------------------------------------------
    // Engine FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    logic pop;
    logic do_step;
    logic done;
    logic last_step;

    assign last_step = (cnt_q == C_STEP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!empty) state_d = S_SHIFT;
            S_SHIFT: if (last_step && empty) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // On the final step the next word is loaded on the same edge, so
    // consecutive words stream through without an idle cycle.
    always_comb begin
        pop     = 1'b0;
        do_step = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: pop = !empty;
            S_SHIFT: begin
                do_step = 1'b1;
                if (last_step) begin
                    pop  = !empty;
                    done = empty;
                end
            end
            default: ;
        endcase
    end

    assign idle = (state_q == S_IDLE) && empty;

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    always_comb begin
        crc_d    = crc_q;
        poly_d   = poly_q;
        xorout_d = xorout_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        ien_d    = ien_q;
        pend_d   = pend_q;
        ovf_d    = ovf_q;

        if (do_step) begin
            crc_d = step_crc;
            sh_d  = step_sh;
            cnt_d = cnt_q - C_STEP;
        end
        if (pop) begin
            sh_d  = fifo_pay_q[rd_ptr_q];
            cnt_d = fifo_len_q[rd_ptr_q];
        end

        // A CPU write to CRC overrides the step computed in the same cycle;
        // the shifter still advances, so that cycle's input bits are lost.
        if (wr_en) begin
            case (bus.rs)
                3'd0: crc_d    = bus.d[31 -: W];
                3'd1: poly_d   = bus.d[31 -: W];
                3'd4: begin
                    ien_d = bus.d[0];
                    if (bus.d[1]) pend_d = 1'b0;
                    if (bus.d[2]) ovf_d  = 1'b0;
                end
                3'd5: xorout_d = bus.d[W-1:0];
                default: ;
            endcase
        end

        // Set beats clear when both land in the same cycle.
        if (done) pend_d = 1'b1;
        if (push_req && full) ovf_d = 1'b1;
    end

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        fill_d   = fill_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_q    <= '0;
            poly_q   <= '0;
            xorout_q <= '0;
            sh_q     <= '0;
            cnt_q    <= '0;
            ien_q    <= 1'b0;
            pend_q   <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            crc_q    <= crc_d;
            poly_q   <= poly_d;
            xorout_q <= xorout_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            ien_q    <= ien_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Storage needs no reset: entries are only read after being written,
    // as governed by the reset pointers and fill count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_pay_q[wr_ptr_q] <= push_payload;
            fifo_len_q[wr_ptr_q] <= wr_len;
        end
    end

    // ------------------------------------------------------------------
    // Read mux and interrupt
    // ------------------------------------------------------------------
    logic [W-1:0] crc_rev;

    always_comb begin
        crc_rev = '0;
        for (int i = 0; i < W; i++) begin
            crc_rev[i] = crc_q[W-1-i];
        end
    end

    always_comb begin
        case (bus.rs)
            3'd0:    bus.q = 32'(crc_q) << (32 - W);
            3'd1:    bus.q = {22'd0, 6'(fill_q), ovf_q, pend_q, full, idle};
            3'd2:    bus.q = 32'(crc_rev ^ xorout_q);
            3'd3:    bus.q = 32'(crc_q ^ xorout_q);
            3'd4:    bus.q = {31'd0, ien_q};
            3'd5:    bus.q = 32'(xorout_q);
            default: bus.q = 32'd0;
        endcase
    end

    assign bus.irq = pend_q && ien_q;

endmodule
`default_nettype wire
